// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse definitions used by the encoder and decoder
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2,
      ST_GAP   = 2'd3
   } morse_state_e;

   localparam int   MAX_SYMS = 5;
   localparam int   LEN_W    = 3;
   localparam int   BITS_W   = MAX_SYMS;
   localparam logic DOT      = 1'b0;
   localparam logic DASH     = 1'b1;

   // Width of a down-counter that must hold values 0..count-1 (never zero width).
   function automatic int cnt_width(input int count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

   function automatic int sym_units(input logic sym, input int dash_units);
      return (sym == DASH) ? dash_units : 1;
   endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// rtl/morse_encoder_if.sv - character request and keying-line bundle of the Morse encoder
interface morse_encoder_if;
   import morse_pkg::*;

   logic              new_i;
   logic [LEN_W-1:0]  len_i;
   logic [BITS_W-1:0] bits_i;
   logic              key_o;
   logic              idle_o;
   logic              done_o;
   logic              err_o;

   modport master (
      output new_i, len_i, bits_i,
      input  key_o, idle_o, done_o, err_o
   );

   modport slave (
      input  new_i, len_i, bits_i,
      output key_o, idle_o, done_o, err_o
   );

endinterface

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - unit prescaler plus loadable unit down-counter
module morse_unit_timer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 4,
   parameter int UNIT_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [UNIT_W-1:0] units_m1_i,
   output logic              expire_o
);

   localparam int                CYC_W    = cnt_width(UNIT_CYCLES);
   localparam logic [CYC_W-1:0]  CYC_MAX  = CYC_W'(UNIT_CYCLES - 1);
   localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);
   localparam logic [UNIT_W-1:0] UNIT_ONE = UNIT_W'(1);

   logic [CYC_W-1:0]  cyc_q,  cyc_d;
   logic [UNIT_W-1:0] unit_q, unit_d;
   logic              run_q,  run_d;
   logic              unit_stb;

   assign unit_stb = (cyc_q == '0);
   // Expires in the last cycle of the loaded interval so the FSM can reload on the same edge.
   assign expire_o = run_q && unit_stb && (unit_q == '0);

   always_comb begin
      cyc_d  = cyc_q;
      unit_d = unit_q;
      run_d  = run_q;
      if (load_i) begin
         cyc_d  = CYC_MAX;
         unit_d = units_m1_i;
         run_d  = 1'b1;
      end else if (run_q) begin
         if (unit_stb) begin
            cyc_d = CYC_MAX;
            if (unit_q == '0) run_d = 1'b0;
            else              unit_d = unit_q - UNIT_ONE;
         end else begin
            cyc_d = cyc_q - CYC_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q  <= '0;
         unit_q <= '0;
         run_q  <= 1'b0;
      end else begin
         cyc_q  <= cyc_d;
         unit_q <= unit_d;
         run_q  <= run_d;
      end
   end

endmodule

// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - keys one Morse character (dots/dashes plus trailing gap) onto a line
module morse_encoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES    = 4,
   parameter int DASH_UNITS     = 3,
   parameter int SYM_GAP_UNITS  = 1,
   parameter int CHAR_GAP_UNITS = 3,
   parameter int WORD_GAP_UNITS = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   morse_encoder_if.slave  bus
);

   localparam int MAX_A     = (DASH_UNITS > CHAR_GAP_UNITS) ? DASH_UNITS : CHAR_GAP_UNITS;
   localparam int MAX_B     = (WORD_GAP_UNITS > SYM_GAP_UNITS) ? WORD_GAP_UNITS : SYM_GAP_UNITS;
   localparam int MAX_UNITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int UNIT_W    = cnt_width(MAX_UNITS);

   localparam logic [UNIT_W-1:0] SYM_M1  = UNIT_W'(SYM_GAP_UNITS - 1);
   localparam logic [UNIT_W-1:0] CHAR_M1 = UNIT_W'(CHAR_GAP_UNITS - 1);
   localparam logic [UNIT_W-1:0] WORD_M1 = UNIT_W'(WORD_GAP_UNITS - 1);

   morse_state_e      state_q, state_d;
   logic [LEN_W-1:0]  len_q,   len_d;
   logic [BITS_W-1:0] bits_q,  bits_d;
   logic [LEN_W-1:0]  idx_q,   idx_d;
   logic              key_q,   key_d;
   logic              idle_q,  idle_d;
   logic              done_q,  done_d;
   logic              err_q,   err_d;
   logic              load;
   logic [UNIT_W-1:0] units_m1;
   logic              expire;

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .UNIT_W      (UNIT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .units_m1_i (units_m1),
      .expire_o   (expire)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      bits_d   = bits_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      load     = 1'b0;
      units_m1 = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.new_i) begin
               if (bus.len_i == '0) begin
                  state_d  = ST_GAP;
                  load     = 1'b1;
                  units_m1 = WORD_M1;
               end else if (bus.len_i > LEN_W'(MAX_SYMS)) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = ST_MARK;
                  len_d    = bus.len_i;
                  bits_d   = bus.bits_i;
                  idx_d    = '0;
                  load     = 1'b1;
                  units_m1 = UNIT_W'(sym_units(bus.bits_i[0], DASH_UNITS) - 1);
               end
            end
         end
         ST_MARK: begin
            if (expire) begin
               load = 1'b1;
               if (idx_q == len_q - LEN_W'(1)) begin
                  state_d  = ST_GAP;
                  units_m1 = CHAR_M1;
               end else begin
                  state_d  = ST_SPACE;
                  units_m1 = SYM_M1;
               end
            end
         end
         ST_SPACE: begin
            if (expire) begin
               state_d  = ST_MARK;
               idx_d    = idx_q + LEN_W'(1);
               load     = 1'b1;
               units_m1 = UNIT_W'(sym_units(bits_q[idx_d], DASH_UNITS) - 1);
            end
         end
         ST_GAP: begin
            if (expire) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      key_d  = (state_d == ST_MARK);
      idle_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         bits_q  <= '0;
         idx_q   <= '0;
         key_q   <= 1'b0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         bits_q  <= bits_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
         idle_q  <= idle_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.key_o  = key_q;
   assign bus.idle_o = idle_q;
   assign bus.done_o = done_q;
   assign bus.err_o  = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - randomized and directed checks of morse_encoder against a waveform model
module tb_morse_encoder;
   import morse_pkg::*;

   localparam int U      = 4;
   localparam int DASH_U = 3;
   localparam int SYM_U  = 1;
   localparam int CHAR_U = 3;
   localparam int WORD_U = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   morse_encoder_if bus();

   morse_encoder #(
      .UNIT_CYCLES    (U),
      .DASH_UNITS     (DASH_U),
      .SYM_GAP_UNITS  (SYM_U),
      .CHAR_GAP_UNITS (CHAR_U),
      .WORD_GAP_UNITS (WORD_U)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted character becomes a queue of per-cycle key levels; the cycle after it drains is done.
   bit   wave[$];
   logic m_key = 1'b0, m_idle = 1'b1, m_done = 1'b0, m_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      bit old_idle;
      int l;
      if (!rst_n) begin
         wave.delete();
         m_key = 1'b0; m_idle = 1'b1; m_done = 1'b0; m_err = 1'b0;
      end else begin
         old_idle = m_idle;
         m_done = 1'b0;
         m_err  = 1'b0;
         if (old_idle && bus.new_i) begin
            l = int'(bus.len_i);
            if (l > 5) m_err = 1'b1;
            else if (l == 0) begin
               repeat (U * WORD_U) wave.push_back(1'b0);
            end else begin
               for (int i = 0; i < l; i++) begin
                  repeat (U * (bus.bits_i[i] ? DASH_U : 1)) wave.push_back(1'b1);
                  if (i < l - 1) repeat (U * SYM_U) wave.push_back(1'b0);
               end
               repeat (U * CHAR_U) wave.push_back(1'b0);
            end
         end
         if (wave.size() > 0) begin
            m_key  = wave.pop_front();
            m_idle = 1'b0;
         end else begin
            if (!old_idle) m_done = 1'b1;
            m_key  = 1'b0;
            m_idle = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      check("key",  bus.key_o,  m_key);
      check("idle", bus.idle_o, m_idle);
      check("done", bus.done_o, m_done);
      check("err",  bus.err_o,  m_err);
   end

   task automatic start_char(input logic [2:0] l, input logic [4:0] b);
      bus.new_i  = 1'b1;
      bus.len_i  = l;
      bus.bits_i = b;
      @(negedge clk);
      bus.new_i  = 1'b0;
      bus.len_i  = 3'($urandom);
      bus.bits_i = 5'($urandom);
   endtask

   // Entered at the negedge of cycle 1 after the accept edge; returns at the negedge of the done cycle.
   task automatic wait_done(input string name, input int exp_cyc, input int exp_rises,
                            input int inject_at, input bit chain);
      int   n = 1;
      int   rises = 0;
      logic prev = 1'b0;
      bit   seen = 1'b0;
      while (n <= 300) begin
         if (bus.key_o && !prev) rises++;
         prev = bus.key_o;
         if (bus.done_o) begin
            seen = 1'b1;
            break;
         end
         if (n == inject_at) begin
            bus.new_i = 1'b1; bus.len_i = 3'd1; bus.bits_i = 5'b00001;
         end else begin
            bus.new_i = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      check({name, " done seen"}, 32'(seen), 1);
      check({name, " done cycle"}, n, exp_cyc);
      check({name, " rises"}, rises, exp_rises);
      if (chain) begin
         bus.new_i = 1'b1; bus.len_i = 3'd1; bus.bits_i = 5'b00001;
      end
   endtask

   initial begin
      bus.new_i = 1'b0; bus.len_i = '0; bus.bits_i = '0;
      repeat (3) @(negedge clk);
      check("reset key", bus.key_o, 0);
      check("reset idle", bus.idle_o, 1);
      check("reset done", bus.done_o, 0);
      check("reset err", bus.err_o, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      start_char(3'd1, 5'b00000);
      wait_done("E", 17, 1, 0, 1'b0);
      @(negedge clk);

      start_char(3'd2, 5'b00010);
      wait_done("A", 33, 2, 0, 1'b0);
      @(negedge clk);

      start_char(3'd0, 5'($urandom));
      wait_done("space", 29, 0, 0, 1'b1);
      @(negedge clk);
      bus.new_i = 1'b0;
      check("T first mark", bus.key_o, 1);
      wait_done("T", 25, 1, 0, 1'b0);
      @(negedge clk);

      start_char(3'd6, 5'($urandom));
      check("err6 pulse", bus.err_o, 1);
      check("err6 idle", bus.idle_o, 1);
      check("err6 key", bus.key_o, 0);
      @(negedge clk);
      check("err6 clears", bus.err_o, 0);
      start_char(3'd7, 5'($urandom));
      check("err7 pulse", bus.err_o, 1);
      repeat (3) @(negedge clk);

      start_char(3'd2, 5'b00010);
      wait_done("A ignore T", 33, 2, 3, 1'b0);
      bus.new_i = 1'b0;
      repeat (2) @(negedge clk);

      start_char(3'd5, 5'b11111);
      repeat (9) @(negedge clk);
      check("zero mid mark", bus.key_o, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async key", bus.key_o, 0);
      check("async idle", bus.idle_o, 1);
      check("async done", bus.done_o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_char(3'd1, 5'b00000);
      wait_done("E after reset", 17, 1, 0, 1'b0);
      @(negedge clk);

      repeat (4000) begin
         bus.new_i  = ($urandom_range(0, 3) == 0);
         bus.len_i  = 3'($urandom_range(0, 7));
         bus.bits_i = 5'($urandom);
         @(negedge clk);
      end
      bus.new_i = 1'b0;
      repeat (150) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
